ssd_scan_driver: RTL and testbench



---
 rtl/ssd_pkg.sv | 23 ++
 rtl/ssd_digit_decode.sv | 36 +++
 rtl/ssd_scan_driver.sv | 164 ++++++++++++++++
 tb/tb_ssd_scan_driver.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared definitions for the multiplexed seven-segment driver.
// Covers segment patterns, converter FSM states and BCD sizing.
package ssd_pkg;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Enough BCD nibbles to hold 2^width-1.
    function automatic int bcd_nibbles(input int width);
        return width / 3 + 1;
    endfunction

endpackage

// File: rtl/ssd_digit_decode.sv
// Nibble to active-low abcdefg pattern with blank and dash overrides.
// Any non-decimal nibble is shown as a dash.
module ssd_digit_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] pattern
);

    // Priority: dash over blank over the digit itself.
    always_comb begin
        pattern = SEG_DASH;
        if (dash) begin
            pattern = SEG_DASH;
        end else if (blank) begin
            pattern = SEG_BLANK;
        end else begin
            case (nibble)
                4'd0:    pattern = SEG_DIGIT[0];
                4'd1:    pattern = SEG_DIGIT[1];
                4'd2:    pattern = SEG_DIGIT[2];
                4'd3:    pattern = SEG_DIGIT[3];
                4'd4:    pattern = SEG_DIGIT[4];
                4'd5:    pattern = SEG_DIGIT[5];
                4'd6:    pattern = SEG_DIGIT[6];
                4'd7:    pattern = SEG_DIGIT[7];
                4'd8:    pattern = SEG_DIGIT[8];
                4'd9:    pattern = SEG_DIGIT[9];
                default: pattern = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Binary to BCD via sequential double-dabble, then time-multiplexed
// drive of DIGITS common-anode digits with optional zero blanking.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  value,
    input  logic              load,
    output logic              busy,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              ovf
);

    localparam int BCD_N = bcd_nibbles(WIDTH);
    localparam int PAD_N = (BCD_N > DIGITS) ? BCD_N : DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_e              state_r, state_next_s;
    logic [WIDTH-1:0]    bin_r;
    logic [BCD_N*4-1:0]  bcd_r, bcd_adj_s;
    logic [PAD_N*4-1:0]  bcd_pad_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [DIGITS*4-1:0] display_r;
    logic                ovf_r, ovf_next_s, busy_r;
    logic [DIV_W-1:0]    presc_r;
    logic [IDX_W-1:0]    idx_r;
    logic [3:0]          nibble_s;
    logic                blank_s;
    logic [6:0]          pattern_s, seg_r;
    logic [DIGITS-1:0]   an_r;

    // Converter state register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_next_s;
    end

    // Converter next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (load) state_next_s = SHIFT;
                else      state_next_s = IDLE;
            end
            SHIFT: begin
                if (cnt_r == CNT_W'(1)) state_next_s = COMMIT;
                else                    state_next_s = SHIFT;
            end
            COMMIT:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Add-3 correction and overflow detection on the padded BCD word.
    always_comb begin
        bcd_adj_s  = bcd_r;
        bcd_pad_s  = '0;
        ovf_next_s = 1'b0;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd_r[i*4 +: 4] >= 4'd5) bcd_adj_s[i*4 +: 4] = bcd_r[i*4 +: 4] + 4'd3;
            else                         bcd_adj_s[i*4 +: 4] = bcd_r[i*4 +: 4];
        end
        bcd_pad_s[BCD_N*4-1:0] = bcd_r;
        for (int i = DIGITS; i < PAD_N; i++) begin
            if (bcd_pad_s[i*4 +: 4] != 4'd0) ovf_next_s = 1'b1;
            else                             ovf_next_s = ovf_next_s;
        end
    end

    // Double-dabble datapath and display register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_r     <= '0;
            bcd_r     <= '0;
            cnt_r     <= '0;
            display_r <= '0;
            ovf_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (load) begin
                        bin_r <= value;
                        bcd_r <= '0;
                        cnt_r <= CNT_W'(WIDTH);
                    end
                end
                SHIFT: begin
                    {bcd_r, bin_r} <= {bcd_adj_s, bin_r} << 1'b1;
                    cnt_r          <= cnt_r - CNT_W'(1);
                end
                COMMIT: begin
                    display_r <= bcd_pad_s[DIGITS*4-1:0];
                    ovf_r     <= ovf_next_s;
                end
                default: ;
            endcase
        end
    end

    // busy trails the FSM by one cycle, so a load in the falling cycle is taken.
    always_ff @(posedge clk) begin
        if (rst) busy_r <= 1'b0;
        else     busy_r <= (state_r != IDLE);
    end

    // Free-running prescaler and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
            idx_r   <= '0;
        end else if (presc_r == DIV_W'(SCAN_DIV - 1)) begin
            presc_r <= '0;
            idx_r   <= (idx_r == IDX_W'(DIGITS - 1)) ? IDX_W'(0) : idx_r + IDX_W'(1);
        end else begin
            presc_r <= presc_r + DIV_W'(1);
        end
    end

    // Select the current nibble; blank it if it and all higher digits are zero.
    always_comb begin
        nibble_s = 4'd0;
        blank_s  = (BLANK_LZ != 0) && (idx_r != IDX_W'(0));
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_r == IDX_W'(i)) nibble_s = display_r[i*4 +: 4];
            else                    nibble_s = nibble_s;
            if ((IDX_W'(i) >= idx_r) && (display_r[i*4 +: 4] != 4'd0)) blank_s = 1'b0;
            else                                                        blank_s = blank_s;
        end
    end

    ssd_digit_decode u_decode (
        .nibble  (nibble_s),
        .blank   (blank_s),
        .dash    (ovf_r),
        .pattern (pattern_s)
    );

    // Registered pin drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r <= SEG_BLANK;
            an_r  <= '1;
        end else begin
            seg_r <= pattern_s;
            an_r  <= ~(DIGITS'(1) << idx_r);
        end
    end

    assign busy = busy_r;
    assign seg  = seg_r;
    assign an   = an_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Randomised and directed bench for ssd_scan_driver against a decimal-arithmetic
// reference; three instances cover zero blanking, no blanking and 2 digits.
module tb_ssd_scan_driver;

    localparam int W   = 8;
    localparam int DIV = 4;

    logic         clk = 1'b0;
    logic         rst, load;
    logic [W-1:0] value;

    logic       busy_a, busy_b, busy_c, ovf_a, ovf_b, ovf_c;
    logic [6:0] seg_a, seg_b, seg_c;
    logic [2:0] an_a, an_b;
    logic [1:0] an_c;

    always #5 clk = ~clk;

    ssd_scan_driver #(.WIDTH(W), .DIGITS(3), .SCAN_DIV(DIV), .BLANK_LZ(1)) u_lz3 (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy_a), .seg(seg_a), .an(an_a), .ovf(ovf_a));
    ssd_scan_driver #(.WIDTH(W), .DIGITS(3), .SCAN_DIV(DIV), .BLANK_LZ(0)) u_nz3 (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy_b), .seg(seg_b), .an(an_b), .ovf(ovf_b));
    ssd_scan_driver #(.WIDTH(W), .DIGITS(2), .SCAN_DIV(DIV), .BLANK_LZ(1)) u_lz2 (
        .clk(clk), .rst(rst), .value(value), .load(load),
        .busy(busy_c), .seg(seg_c), .an(an_c), .ovf(ovf_c));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: edges since reset, pending conversion, shown value.
    int k          = 0;
    int conv_start = -1;
    int conv_val   = 0;
    int disp_val   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b0000001;  1: return 7'b1001111;
            2: return 7'b0010010;  3: return 7'b0000110;
            4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;
            8: return 7'b0000000;  9: return 7'b0000100;
            default: return 7'b1111110;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int i, input int ndig, input bit blz);
        if (v >= pow10(ndig)) return 7'b1111110;
        if (blz && i > 0 && v < pow10(i)) return 7'b1111111;
        return enc((v / pow10(i)) % 10);
    endfunction

    function automatic bit model_idle();
        return (conv_start < 0) || (k >= conv_start + W + 2);
    endfunction

    task automatic tick();
        int         idx3, idx2;
        logic [6:0] es_a, es_b, es_c;
        logic [2:0] ea3;
        logic [1:0] ea2;
        bit         eb, eo3, eo2;
        @(posedge clk);
        if (rst) begin
            k = 0; conv_start = -1; disp_val = 0;
            es_a = 7'b1111111; es_b = 7'b1111111; es_c = 7'b1111111;
            ea3 = 3'b111; ea2 = 2'b11; eb = 1'b0;
        end else begin
            idx3 = (k / DIV) % 3;
            idx2 = (k / DIV) % 2;
            es_a = exp_seg(disp_val, idx3, 3, 1'b1);
            es_b = exp_seg(disp_val, idx3, 3, 1'b0);
            es_c = exp_seg(disp_val, idx2, 2, 1'b1);
            ea3  = ~(3'b001 << idx3);
            ea2  = ~(2'b01 << idx2);
            eb   = (conv_start >= 0) && (k >= conv_start + 1) && (k <= conv_start + W + 1);
            if (conv_start >= 0 && k == conv_start + W + 1) disp_val = conv_val;
            if (load && model_idle()) begin
                conv_start = k;
                conv_val   = int'(value);
            end
            k++;
        end
        eo3 = !rst && (disp_val >= 1000);
        eo2 = !rst && (disp_val >= 100);
        #1;
        check_eq("seg_lz3", 32'(seg_a), 32'(es_a));
        check_eq("seg_nz3", 32'(seg_b), 32'(es_b));
        check_eq("seg_lz2", 32'(seg_c), 32'(es_c));
        check_eq("an_lz3",  32'(an_a),  32'(ea3));
        check_eq("an_nz3",  32'(an_b),  32'(ea3));
        check_eq("an_lz2",  32'(an_c),  32'(ea2));
        check_eq("busy_lz3", 32'(busy_a), 32'(eb));
        check_eq("busy_lz2", 32'(busy_c), 32'(eb));
        check_eq("ovf_lz3", 32'(ovf_a), 32'(eo3));
        check_eq("ovf_nz3", 32'(ovf_b), 32'(eo3));
        check_eq("ovf_lz2", 32'(ovf_c), 32'(eo2));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input int v);
        value = W'(v);
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && !model_idle(); i++) tick();
    endtask

    task automatic show(input int v);
        do_load(v);
        wait_idle();
        run(3 * DIV + 2);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0;
        run(3);
        rst = 1'b0;
        run(24);

        show(237);
        show(5);
        show(150);
        show(99);
        show(0);
        show(255);

        // Second load two cycles later lands while busy and is dropped.
        do_load(42);
        tick();
        do_load(7);
        wait_idle();
        run(3 * DIV + 2);

        // Load presented exactly on the cycle busy falls.
        do_load(42);
        wait_idle();
        show(7);

        // Reset in the middle of a conversion.
        do_load(200);
        run(3);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(3 * DIV + 2);
        show(200);

        for (int i = 0; i < 400; i++) begin
            value = W'($urandom);
            load  = ($urandom_range(0, 5) == 0);
            tick();
        end
        load = 1'b0;
        wait_idle();
        run(3 * DIV + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
